// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/func constants, decoded-field struct, skid occupancy states.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rsc;
    logic [4:0]  rtc;
    logic [4:0]  rdc;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [15:0] imme;
    logic [25:0] index;
    logic        is_rtype;
    logic        is_jump;
    logic        is_branch;
  } id_fields_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } id_occ_e;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/id_field_decode.sv
// Combinational split of an instruction word into fields, extended immediate and class flags.
// With ID_TARGET_EN defined it also forms the jump and branch targets from the PC.
module id_field_decode
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
`ifdef ID_TARGET_EN
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] jtarget,
  output logic [XLEN-1:0] btarget,
`endif
  output id_fields_t      fields,
  output logic [XLEN-1:0] imm_ext
);

  logic [5:0]              op;
  logic [5:0]              func;
  logic signed [15:0]      imme_s;
  logic signed [31:0]      lui_s;
  logic signed [XLEN-1:0]  sext_imme;
  logic signed [XLEN-1:0]  sext_lui;

  assign op        = instr[31:26];
  assign func      = instr[5:0];
  assign imme_s    = instr[15:0];
  assign lui_s     = {instr[15:0], 16'h0000};
  assign sext_imme = imme_s;
  assign sext_lui  = lui_s;

  assign fields.op        = op;
  assign fields.rsc       = instr[25:21];
  assign fields.rtc       = instr[20:16];
  assign fields.rdc       = instr[15:11];
  assign fields.sa        = instr[10:6];
  assign fields.func      = func;
  assign fields.imme      = instr[15:0];
  assign fields.index     = instr[25:0];
  assign fields.is_rtype  = (op == OP_SPECIAL) || (op == OP_SPECIAL2);
  assign fields.is_jump   = (op == OP_J) || (op == OP_JAL) ||
                            ((op == OP_SPECIAL) && ((func == FN_JR) || (func == FN_JALR)));
  assign fields.is_branch = is_branch_op(op);

  // Logical immediates zero-extend; lui places the field in the upper half first.
  always_comb begin
    imm_ext = sext_imme;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = XLEN'(instr[15:0]);
      OP_LUI:                   imm_ext = sext_lui;
      default:                  ;
    endcase
  end

`ifdef ID_TARGET_EN
  logic [XLEN-1:0] pc4;

  assign pc4     = pc + XLEN'(4);
  assign jtarget = {pc4[XLEN-1:28], instr[25:0], 2'b00};
  assign btarget = pc4 + (imm_ext << 2);
`endif

endmodule

// File: rtl/id_stage.sv
// Registered MIPS decode stage with a two-entry skid buffer; in_ready depends only on state.
// Optional ID_TARGET_EN adds precomputed jump/branch targets (jtarget, btarget).
module id_stage
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FLUSH_CLR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op,
  output logic [4:0]      rsc,
  output logic [4:0]      rtc,
  output logic [4:0]      rdc,
  output logic [4:0]      sa,
  output logic [5:0]      func,
  output logic [15:0]     imme,
  output logic [25:0]     index,
  output logic [XLEN-1:0] imm_ext,
  output logic            is_rtype,
  output logic            is_jump,
  output logic            is_branch,
`ifdef ID_TARGET_EN
  output logic [XLEN-1:0] jtarget,
  output logic [XLEN-1:0] btarget,
`endif
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    id_fields_t      f;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
`ifdef ID_TARGET_EN
    logic [XLEN-1:0] jtarget;
    logic [XLEN-1:0] btarget;
`endif
  } entry_t;

  id_occ_e state;
  entry_t  dec_entry;
  entry_t  main_q;
  entry_t  skid_q;
  logic    in_ready_q;
  logic    push;
  logic    pop;

  id_field_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
`ifdef ID_TARGET_EN
    .pc      (in_pc),
    .jtarget (dec_entry.jtarget),
    .btarget (dec_entry.btarget),
`endif
    .fields  (dec_entry.f),
    .imm_ext (dec_entry.imm_ext)
  );

  assign dec_entry.pc = in_pc;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != OCC_EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Main drives the outputs; skid only catches the word accepted while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      if (FLUSH_CLR) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        OCC_EMPTY: begin
          in_ready_q <= 1'b1;
          if (push) begin
            main_q <= dec_entry;
            state  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            main_q <= dec_entry;
          end else if (push) begin
            skid_q     <= dec_entry;
            state      <= OCC_TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            state      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= OCC_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op        = main_q.f.op;
  assign rsc       = main_q.f.rsc;
  assign rtc       = main_q.f.rtc;
  assign rdc       = main_q.f.rdc;
  assign sa        = main_q.f.sa;
  assign func      = main_q.f.func;
  assign imme      = main_q.f.imme;
  assign index     = main_q.f.index;
  assign is_rtype  = main_q.f.is_rtype;
  assign is_jump   = main_q.f.is_jump;
  assign is_branch = main_q.f.is_branch;
  assign imm_ext   = main_q.imm_ext;
  assign out_pc    = main_q.pc;
`ifdef ID_TARGET_EN
  assign jtarget   = main_q.jtarget;
  assign btarget   = main_q.btarget;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage: a 32-bit instance carries the checks and a
// 64-bit instance shares its inputs for the wide immediate; target checks need ID_TARGET_EN.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, is_rtype, is_jump, is_branch;
  logic [5:0]  op, func;
  logic [4:0]  rsc, rtc, rdc, sa;
  logic [15:0] imme;
  logic [25:0] index;
  logic [31:0] imm_ext, out_pc;
`ifdef ID_TARGET_EN
  logic [31:0] jtarget, btarget;
  logic [63:0] jtarget_w, btarget_w;
`endif

  logic        in_ready_w, out_valid_w, is_rtype_w, is_jump_w, is_branch_w;
  logic [5:0]  op_w, func_w;
  logic [4:0]  rsc_w, rtc_w, rdc_w, sa_w;
  logic [15:0] imme_w;
  logic [25:0] index_w;
  logic [63:0] imm_ext_w, out_pc_w, in_pc_w;

  int errors = 0;
  int checks = 0;

  assign in_pc_w = {32'h0, in_pc};

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .FLUSH_CLR(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rsc(rsc), .rtc(rtc), .rdc(rdc), .sa(sa), .func(func),
    .imme(imme), .index(index), .imm_ext(imm_ext),
    .is_rtype(is_rtype), .is_jump(is_jump), .is_branch(is_branch),
`ifdef ID_TARGET_EN
    .jtarget(jtarget), .btarget(btarget),
`endif
    .out_pc(out_pc)
  );

  id_stage #(.XLEN(64), .FLUSH_CLR(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_instr(in_instr), .in_pc(in_pc_w), .flush(flush),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .op(op_w), .rsc(rsc_w), .rtc(rtc_w), .rdc(rdc_w), .sa(sa_w), .func(func_w),
    .imme(imme_w), .index(index_w), .imm_ext(imm_ext_w),
    .is_rtype(is_rtype_w), .is_jump(is_jump_w), .is_branch(is_branch_w),
`ifdef ID_TARGET_EN
    .jtarget(jtarget_w), .btarget(btarget_w),
`endif
    .out_pc(out_pc_w)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rsc, rtc, rdc, sa;
    logic [5:0]  func;
    logic [15:0] imme;
    logic [25:0] index;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  cls;
    logic        chk_tgt;
    logic [31:0] jt, bt;
  } vec_t;

  vec_t vecs[12];

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // instr, pc, op, rs, rt, rd, sa, func, imme, index, imm32, imm64, {rtype,jump,branch}, chk, jt, bt
    vecs[0]  = '{32'h3421_8000, 32'h0040_0100, 6'h0D, 5'd1,  5'd1,  5'd16, 5'd0,  6'h00, 16'h8000, 26'h021_8000, 32'h0000_8000, 64'h0000_0000_0000_8000, 3'b000, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{32'h2001_FFFC, 32'h0040_0104, 6'h08, 5'd0,  5'd1,  5'd31, 5'd31, 6'h3C, 16'hFFFC, 26'h001_FFFC, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'b000, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{32'h3C01_8000, 32'h0040_0108, 6'h0F, 5'd0,  5'd1,  5'd16, 5'd0,  6'h00, 16'h8000, 26'h001_8000, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'b000, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{32'h0800_0010, 32'h0040_0000, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 16'h0010, 26'h000_0010, 32'h0000_0010, 64'h0000_0000_0000_0010, 3'b010, 1'b1, 32'h0000_0040, 32'h0040_0044};
    vecs[4]  = '{32'h1000_FFFF, 32'h0040_0010, 6'h04, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h000_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b1, 32'h0003_FFFC, 32'h0040_0010};
    vecs[5]  = '{32'h03E0_0008, 32'h0040_010C, 6'h00, 5'd31, 5'd0,  5'd0,  5'd0,  6'h08, 16'h0008, 26'h3E0_0008, 32'h0000_0008, 64'h0000_0000_0000_0008, 3'b110, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{32'h3042_F00F, 32'h0040_0110, 6'h0C, 5'd2,  5'd2,  5'd30, 5'd0,  6'h0F, 16'hF00F, 26'h042_F00F, 32'h0000_F00F, 64'h0000_0000_0000_F00F, 3'b000, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{32'h7022_1002, 32'h0040_0114, 6'h1C, 5'd1,  5'd2,  5'd2,  5'd0,  6'h02, 16'h1002, 26'h022_1002, 32'h0000_1002, 64'h0000_0000_0000_1002, 3'b100, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{32'h1C20_FFFE, 32'h0040_0118, 6'h07, 5'd1,  5'd0,  5'd31, 5'd31, 6'h3E, 16'hFFFE, 26'h020_FFFE, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 3'b001, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{32'h0040_F809, 32'h0040_011C, 6'h00, 5'd2,  5'd0,  5'd31, 5'd0,  6'h09, 16'hF809, 26'h040_F809, 32'hFFFF_F809, 64'hFFFF_FFFF_FFFF_F809, 3'b110, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{32'h0C10_0000, 32'h0040_0120, 6'h03, 5'd0,  5'd16, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h010_0000, 32'h0000_0000, 64'h0000_0000_0000_0000, 3'b010, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{32'h0420_FFFF, 32'h0040_0124, 6'h01, 5'd1,  5'd0,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h020_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 32'h0, 32'h0};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_op", op, 0);
    checkOutput("post_rst_imm_ext", imm_ext, 0);
    checkOutput("post_rst_out_pc", out_pc, 0);

    // Back-to-back pushes with out_ready high: one word per cycle, one cycle latency.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("v%0d_out_valid", i), out_valid, 1);
      checkOutput($sformatf("v%0d_in_ready", i), in_ready, 1);
      checkOutput($sformatf("v%0d_op", i), op, vecs[i].op);
      checkOutput($sformatf("v%0d_rsc", i), rsc, vecs[i].rsc);
      checkOutput($sformatf("v%0d_rtc", i), rtc, vecs[i].rtc);
      checkOutput($sformatf("v%0d_rdc", i), rdc, vecs[i].rdc);
      checkOutput($sformatf("v%0d_sa", i), sa, vecs[i].sa);
      checkOutput($sformatf("v%0d_func", i), func, vecs[i].func);
      checkOutput($sformatf("v%0d_imme", i), imme, vecs[i].imme);
      checkOutput($sformatf("v%0d_index", i), index, vecs[i].index);
      checkOutput($sformatf("v%0d_imm_ext", i), imm_ext, vecs[i].imm32);
      checkOutput($sformatf("v%0d_imm_ext64", i), imm_ext_w, vecs[i].imm64);
      checkOutput($sformatf("v%0d_class", i), {is_rtype, is_jump, is_branch}, vecs[i].cls);
      checkOutput($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d_out_pc64", i), out_pc_w, {32'h0, vecs[i].pc});
`ifdef ID_TARGET_EN
      if (vecs[i].chk_tgt) begin
        checkOutput($sformatf("v%0d_jtarget", i), jtarget, vecs[i].jt);
        checkOutput($sformatf("v%0d_btarget", i), btarget, vecs[i].bt);
      end
`endif
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("drain_out_valid", out_valid, 0);
    checkOutput("drain_in_ready", in_ready, 1);

    // Back-pressure: fill both entries, offer a third word, then drain in order.
    applyStimulus(1'b1, vecs[0].instr, vecs[0].pc, 1'b0, 1'b0);
    step();
    checkOutput("bp_a_in_ready", in_ready, 1);
    applyStimulus(1'b1, vecs[1].instr, vecs[1].pc, 1'b0, 1'b0);
    step();
    checkOutput("bp_two_in_ready", in_ready, 0);
    checkOutput("bp_two_out_valid", out_valid, 1);
    checkOutput("bp_two_op", op, 6'h0D);
    applyStimulus(1'b1, vecs[2].instr, vecs[2].pc, 1'b0, 1'b0);
    step();
    checkOutput("bp_hold_op", op, 6'h0D);
    checkOutput("bp_hold_imm_ext", imm_ext, 32'h0000_8000);
    checkOutput("bp_hold_out_pc", out_pc, 32'h0040_0100);
    checkOutput("bp_hold_in_ready", in_ready, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("bp_pop1_out_valid", out_valid, 1);
    checkOutput("bp_pop1_op", op, 6'h08);
    checkOutput("bp_pop1_imm_ext", imm_ext, 32'hFFFF_FFFC);
    checkOutput("bp_pop1_in_ready", in_ready, 1);
    step();
    checkOutput("bp_pop2_out_valid", out_valid, 0);
    checkOutput("bp_pop2_in_ready", in_ready, 1);
    step();
    checkOutput("bp_no_third_word", out_valid, 0);

    // Flush while TWO with a word offered: everything is dropped and payload cleared.
    applyStimulus(1'b1, vecs[0].instr, vecs[0].pc, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, vecs[1].instr, vecs[1].pc, 1'b0, 1'b0);
    step();
    checkOutput("fl_pre_in_ready", in_ready, 0);
    applyStimulus(1'b1, vecs[3].instr, vecs[3].pc, 1'b0, 1'b1);
    step();
    checkOutput("fl_out_valid", out_valid, 0);
    checkOutput("fl_in_ready", in_ready, 1);
    checkOutput("fl_clr_op", op, 0);
    checkOutput("fl_clr_out_pc", out_pc, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("fl_post_out_valid", out_valid, 0);

    // Flush in ONE with an accepted push: that word must never appear.
    applyStimulus(1'b1, vecs[6].instr, vecs[6].pc, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, vecs[7].instr, vecs[7].pc, 1'b1, 1'b1);
    step();
    checkOutput("fl1_out_valid", out_valid, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkOutput("fl1_post_out_valid", out_valid, 0);
    checkOutput("fl1_in_ready", in_ready, 1);

    // Reset in ONE while stalled clears all outputs.
    applyStimulus(1'b1, vecs[0].instr, vecs[0].pc, 1'b0, 1'b0);
    step();
    checkOutput("rs_pre_out_valid", out_valid, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    checkOutput("rs_out_valid", out_valid, 0);
    checkOutput("rs_in_ready", in_ready, 0);
    checkOutput("rs_op", op, 0);
    checkOutput("rs_rsc", rsc, 0);
    checkOutput("rs_imme", imme, 0);
    checkOutput("rs_index", index, 0);
    checkOutput("rs_imm_ext", imm_ext, 0);
    checkOutput("rs_out_pc", out_pc, 0);
    checkOutput("rs_imm_ext64", imm_ext_w, 0);
    rst = 1'b0;
    step();
    checkOutput("rs_post_in_ready", in_ready, 1);
    checkOutput("rs_post_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered instruction-decode stage for the 54-instruction MIPS core. It accepts fetched instruction words with a valid/ready handshake and splits each word into its opcode, register, shift, function, immediate and index fields. It also produces an XLEN-wide extended immediate and class flags, and holds the result in a two-entry skid buffer so that back-pressure from the execute side never creates a combinational ready path. It sits between fetch and the register-file/execute stage.

## Interface
- XLEN, 32, datapath width; sets the widths of `imm_ext` and the PC ports; legal values are 32 or 64.
- FLUSH_CLR, 1, when 1 a flush also zeroes the payload registers; when 0 only the valid bits are cleared.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  stage can accept; registered; equals `!skid_valid`.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- flush  in  1  discard all held and incoming words.
- out_valid  out  1  decoded word available.
- out_ready  in  1  consumer accepts.
- op / rsc / rtc / rdc / sa / func  out  6/5/5/5/5/6  bit fields [31:26] / [25:21] / [20:16] / [15:11] / [10:6] / [5:0].
- imme  out  16  raw field [15:0].
- index  out  26  raw field [25:0].
- imm_ext  out  XLEN  extended immediate.
- is_rtype, is_jump, is_branch  out  1 each  class flags.
- out_pc  out  XLEN  PC carried with the word.
- jtarget, btarget  out  XLEN each  present only with `ID_TARGET_EN`.

## Operation
- Occupancy FSM with three states: EMPTY, ONE, TWO. The main register drives the outputs; the skid register holds an overflow word.
- Define push = `in_valid & in_ready` and pop = `out_valid & out_ready`.
- EMPTY, on push: → ONE; the word loads into main.
- ONE:
  - push & pop → ONE; main is replaced by the new word.
  - push & !pop → TWO; the new word goes to skid.
  - pop & !push → EMPTY.
- TWO:
  - pop → ONE; skid moves to main.
  - push cannot occur in TWO because `in_ready` = 0.
- `out_valid` = state != EMPTY.
- Decode happens at push time, so both registers store decoded fields rather than raw words.
- `imm_ext` rules:
  - op 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend `imme`.
  - op 0x0F (lui): sign-extend of {`imme`, 16'h0}.
  - All other opcodes: sign-extend `imme`.
- Class flags:
  - `is_rtype` = op 0x00 or 0x1C.
  - `is_jump` = op 0x02, 0x03, or (op 0x00 and func 0x08/0x09).
  - `is_branch` = op 0x01, 0x04–0x07.
- Flush:
  - The next state is EMPTY regardless of push or pop in the same cycle. A concurrent input word is dropped, and a concurrent pop still counts as consumed by the consumer.
  - `in_ready` = 1 in the cycle after the flush.
  - When FLUSH_CLR = 1, the payload registers are zeroed.
- Priority: rst > flush > handshake.

## Timing
- Latency: one cycle from push to `out_valid`.
- Throughput: one word per cycle while `out_ready` is held high.
- All outputs are registered, with no combinational path from input to output. `in_ready` depends only on state.
- Reset values: `out_valid` = 0, `in_ready` = 0 during rst and 1 in the first cycle after it, all field, imm, PC and target outputs = 0, state = EMPTY.
- rst asserted mid-transfer discards both entries. No partial word is ever presented.
- While `out_valid` & !`out_ready`, all outputs hold stable.

## Configuration
- `ID_TARGET_EN` defined:
  - `jtarget` = {(`out_pc`+4)[XLEN-1:28], `index`, 2'b00}.
  - `btarget` = `out_pc` + 4 + (`imm_ext` << 2), wrapping modulo 2^XLEN.
  - Both are computed at push and stored in both entries.
  - For non-jump or non-branch words the values are don't-care, but they are still deterministic.
- `ID_TARGET_EN` undefined: `jtarget` and `btarget` ports and their registers are absent.

## Structure
- Shared package `mips_pkg`:
  - opcode and func constants (OP_SPECIAL, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_J, OP_JAL, OP_REGIMM, OP_BEQ…OP_BGTZ, OP_SPECIAL2, FN_JR, FN_JALR);
  - the struct `id_fields_t` holding all decoded outputs;
  - the occupancy enum `id_occ_e`.
- Sub-module `id_field_decode`: purely combinational, maps instr (and pc) to `id_fields_t`. It is instantiated once, on the input side.

## Test plan
- Reset, then push ori 0x3421_8000 with `out_ready` = 1 → next cycle `out_valid` = 1, op = 0x0D, rsc = 1, rtc = 1, `imm_ext` = 0x0000_8000.
- Push addi 0x2001_FFFC → `imm_ext` = 0xFFFF_FFFC. Push lui 0x3C01_8000 with XLEN = 64 → `imm_ext` = 0xFFFF_FFFF_8000_0000.
- Back-pressure: hold `out_ready` = 0 and push two words → state TWO, `in_ready` = 0, the first word stays stable. Raise `out_ready` for two cycles → both words emerge in order and `in_ready` = 1.
- Flush while in TWO with a concurrent push → next cycle `out_valid` = 0, `in_ready` = 1, and the pushed word never appears.
- With `ID_TARGET_EN`:
  - j 0x0800_0010 at pc 0x0040_0000 → `jtarget` = 0x0000_0040.
  - beq offset −1 at pc 0x0040_0010 → `btarget` = 0x0040_0010.
- Assert rst while in ONE with `out_ready` = 0 → next cycle `out_valid` = 0 and all outputs are zero.
